ram_loader: RTL and testbench
=============================

Name: ram_loader

Overview:
- Boot-time program loader that sits directly upstream of the 256x8 RAM and drives its addr/we/oe/data pins.
- Accepts a framed byte stream from a host link over a valid/ready handshake: LEN, LEN data bytes, then CHK.
- Writes the data bytes into RAM from BASE_ADDR, reads them back to confirm, and holds the CPU halted for the whole load.

Parameters:
- BASE_ADDR, 8'h00, first RAM address written; addresses wrap modulo 256.

Ports:
- clk  input  1  system clock; all state changes on posedge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  one-cycle pulse that begins a load; honoured in IDLE, DONE and ERR only.
- in_data  input  8  stream byte.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  loader can accept a byte this cycle.
- ram_addr  output  8  RAM address.
- ram_we  output  1  RAM write enable.
- ram_oe  output  1  RAM output enable.
- ram_data  inout  8  RAM data bus; driven only while ram_we=1, otherwise high-Z.
- busy  output  1  load in progress.
- cpu_halt  output  1  equals busy.
- done  output  1  load completed and verified; held until the next start or rst.
- error  output  1  load failed; held until the next start or rst.
- err_code  output  2  00 none, 01 stream checksum mismatch, 10 readback mismatch.

Behaviour:
- Reset: state IDLE. All outputs 0, ram_data high-Z, counters and sums cleared. Reset mid-load abandons the load immediately; bytes already written stay in RAM and no further writes occur.
- A byte is accepted at a posedge where in_valid and in_ready are both 1. in_ready is 1 only in GET_LEN, GET_BYTE and GET_CHK.
- IDLE/DONE/ERR + start -> GET_LEN. done, error and err_code clear on that same edge.
- GET_LEN: latch len. len=0 means 256 bytes. Clear idx and wsum -> GET_BYTE.
- GET_BYTE: latch the byte into hold, wsum += byte (mod 256) -> WRITE.
- WRITE (exactly one cycle): ram_addr = BASE_ADDR+idx (8-bit wrap), ram_we=1, ram_data=hold. Then idx++. If idx reached len -> GET_CHK, else -> GET_BYTE.
- Write throughput is 1 byte per 2 cycles with in_valid held high. Stalls of any length in the GET_* states are legal.
- GET_CHK: latch chk. If chk != wsum, set err_code=01 -> ERR, with no readback. Otherwise clear idx and rsum -> V_READ.
- V_READ: ram_addr = BASE_ADDR+idx, ram_we=0, ram_oe=0. The RAM registers its read buffer at this edge -> V_CMP.
- V_CMP: ram_addr unchanged, ram_oe=1. Sample ram_data at the edge, rsum += ram_data, idx++. If idx reached len, go to CHECK; else -> V_READ.
- CHECK: if rsum == chk -> DONE, else err_code=10 -> ERR.
- busy=1 in every state except IDLE, DONE and ERR. ram_we and ram_oe are never 1 together.
- done=1 only in DONE; error=1 only in ERR.
- Total latency with in_valid continuously high: 1 (LEN) + 2L (write) + 1 (CHK) + 2L (readback) + 1 (CHECK) = 4L+3 cycles from the GET_LEN entry edge to DONE.
- start while busy is ignored. rst has priority over start.
- Idle bus values: ram_addr holds its last value, ram_we=0, ram_oe=0.

Decomposition:
- Package ram_loader_pkg holds the state enum (IDLE, GET_LEN, GET_BYTE, WRITE, GET_CHK, V_READ, V_CMP, CHECK, DONE, ERR), the err_code constants (ERR_NONE, ERR_STREAM, ERR_READBACK) and the 8-bit address/data widths.
- One sub-module, ldr_sum8: an 8-bit modulo accumulator with clear and add-enable. It is instantiated twice, for wsum and rsum.

Test Plan:
- Load LEN=3, data 0x11 0x22 0x33, CHK=0x66 with BASE_ADDR=0x10, valid held high -> mem[0x10..0x12]=11,22,33; done=1 and err_code=00 on cycle 15; busy and cpu_halt high throughout.
- Same stream with CHK=0x67 -> no readback cycles; error=1, err_code=01 on the cycle after CHK is accepted; mem[0x10..0x12] already written.
- BASE_ADDR=0xFE, LEN=4, data 01 02 03 04, CHK=0x0A -> writes land at 0xFE, 0xFF, 0x00, 0x01; done=1.
- LEN=0x00 with 256 bytes of value i, CHK=0x80 -> all 256 locations written; done=1 after 1027 cycles.
- Bench forces one RAM location to corrupt on readback (e.g. bit 0 flipped in mem[0x11] after the write) -> error=1, err_code=10.
- Random in_valid gaps, start pulsed mid-load, then rst asserted during V_READ -> the mid-load start is ignored; after rst all outputs are 0 and ram_data is Z; a fresh start then completes a load normally.

Source files
------------

// File: rtl/ram_loader_pkg.sv
// Shared types and constants for the boot-time RAM loader and its accumulator.
// Imported by ram_loader and ldr_sum8.
package ram_loader_pkg;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 8;
  // len/idx are one bit wider than an address so that a length of 256 is representable
  localparam int CNT_W  = ADDR_W + 1;

  typedef enum logic [3:0] {
    IDLE,
    GET_LEN,
    GET_BYTE,
    WRITE,
    GET_CHK,
    V_READ,
    V_CMP,
    CHECK,
    DONE,
    ERR
  } state_t;

  localparam logic [1:0] ERR_NONE     = 2'b00;
  localparam logic [1:0] ERR_STREAM   = 2'b01;
  localparam logic [1:0] ERR_READBACK = 2'b10;

  // A LEN byte of zero encodes a full 256-byte image.
  function automatic logic [CNT_W-1:0] len_decode(input logic [DATA_W-1:0] b);
    return (b == '0) ? CNT_W'(1 << DATA_W) : {1'b0, b};
  endfunction

endpackage

// File: rtl/ldr_sum8.sv
// Modulo-256 byte accumulator with synchronous clear and add enable.
// Clear takes priority over add.
module ldr_sum8
  import ram_loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              i_clr,
  input  logic              i_add_en,
  input  logic [DATA_W-1:0] i_data,
  output logic [DATA_W-1:0] o_sum
);

  logic [DATA_W-1:0] r_sum;

  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_sum <= '0;
    end else if (i_add_en) begin
      r_sum <= r_sum + i_data;
    end
  end

  assign o_sum = r_sum;

endmodule

// File: rtl/ram_loader.sv
// Boot-time loader: takes a LEN/data/CHK byte stream, writes it into the 256x8 RAM
// from BASE_ADDR, reads it back to verify, and holds the CPU halted throughout.
module ram_loader
  import ram_loader_pkg::*;
#(
  parameter logic [ADDR_W-1:0] BASE_ADDR = 8'h00
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic              ram_oe,
  inout  wire  [DATA_W-1:0] ram_data,
  output logic              busy,
  output logic              cpu_halt,
  output logic              done,
  output logic              error,
  output logic [1:0]        err_code
);

  state_t            r_state;
  state_t            w_state_next;
  logic [CNT_W-1:0]  r_len;
  logic [CNT_W-1:0]  r_idx;
  logic [CNT_W-1:0]  w_idx_inc;
  logic [DATA_W-1:0] r_hold;
  logic [DATA_W-1:0] r_chk;
  logic [ADDR_W-1:0] r_addr;
  logic [1:0]        r_err_code;

  logic              w_accept;
  logic              w_last;
  logic              w_idle_like;
  logic              w_chk_ok;
  logic              w_wsum_clr;
  logic              w_wsum_add;
  logic              w_rsum_clr;
  logic              w_rsum_add;
  logic [DATA_W-1:0] w_wsum;
  logic [DATA_W-1:0] w_rsum;

  assign w_idx_inc   = r_idx + 1'b1;
  assign w_last      = (w_idx_inc == r_len);
  assign w_idle_like = (r_state == IDLE) || (r_state == DONE) || (r_state == ERR);
  assign in_ready    = (r_state == GET_LEN) || (r_state == GET_BYTE) || (r_state == GET_CHK);
  assign w_accept    = in_valid && in_ready;
  assign w_chk_ok    = (in_data == w_wsum);

  // RAM bus: address is registered so it holds its last value between accesses
  assign ram_we   = (r_state == WRITE);
  assign ram_oe   = (r_state == V_CMP);
  assign ram_addr = r_addr;
  assign ram_data = ram_we ? r_hold : {DATA_W{1'bz}};

  assign busy     = !w_idle_like;
  assign cpu_halt = busy;
  assign done     = (r_state == DONE);
  assign error    = (r_state == ERR);
  assign err_code = r_err_code;

  ldr_sum8 u_wsum (
    .clk      (clk),
    .rst      (rst),
    .i_clr    (w_wsum_clr),
    .i_add_en (w_wsum_add),
    .i_data   (in_data),
    .o_sum    (w_wsum)
  );

  ldr_sum8 u_rsum (
    .clk      (clk),
    .rst      (rst),
    .i_clr    (w_rsum_clr),
    .i_add_en (w_rsum_add),
    .i_data   (ram_data),
    .o_sum    (w_rsum)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_wsum_clr   = 1'b0;
    w_wsum_add   = 1'b0;
    w_rsum_clr   = 1'b0;
    w_rsum_add   = 1'b0;
    case (r_state)
      IDLE, DONE, ERR: begin
        if (start) w_state_next = GET_LEN;
      end
      GET_LEN: begin
        if (w_accept) begin
          w_wsum_clr   = 1'b1;
          w_state_next = GET_BYTE;
        end
      end
      GET_BYTE: begin
        if (w_accept) begin
          w_wsum_add   = 1'b1;
          w_state_next = WRITE;
        end
      end
      WRITE: begin
        w_state_next = w_last ? GET_CHK : GET_BYTE;
      end
      GET_CHK: begin
        if (w_accept) begin
          w_rsum_clr   = w_chk_ok;
          w_state_next = w_chk_ok ? V_READ : ERR;
        end
      end
      V_READ: begin
        w_state_next = V_CMP;
      end
      V_CMP: begin
        w_rsum_add   = 1'b1;
        w_state_next = w_last ? CHECK : V_READ;
      end
      CHECK: begin
        w_state_next = (w_rsum == r_chk) ? DONE : ERR;
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_len      <= '0;
      r_idx      <= '0;
      r_hold     <= '0;
      r_chk      <= '0;
      r_addr     <= '0;
      r_err_code <= ERR_NONE;
    end else begin
      case (r_state)
        IDLE, DONE, ERR: begin
          if (start) r_err_code <= ERR_NONE;
        end
        GET_LEN: begin
          if (w_accept) begin
            r_len <= len_decode(in_data);
            r_idx <= '0;
          end
        end
        GET_BYTE: begin
          // address is set up here so it is stable for the whole WRITE cycle
          if (w_accept) begin
            r_hold <= in_data;
            r_addr <= BASE_ADDR + r_idx[ADDR_W-1:0];
          end
        end
        WRITE: begin
          r_idx <= w_idx_inc;
        end
        GET_CHK: begin
          if (w_accept) begin
            r_chk <= in_data;
            if (w_chk_ok) begin
              r_idx  <= '0;
              r_addr <= BASE_ADDR;
            end else begin
              r_err_code <= ERR_STREAM;
            end
          end
        end
        V_CMP: begin
          r_idx <= w_idx_inc;
          if (!w_last) r_addr <= BASE_ADDR + w_idx_inc[ADDR_W-1:0];
        end
        CHECK: begin
          if (w_rsum != r_chk) r_err_code <= ERR_READBACK;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ram_loader.sv
// Self-checking bench for ram_loader: two instances (BASE_ADDR 0x10 and 0xFE) share one
// stimulus stream; each has its own RAM model and a per-cycle compare against a load model.
module tb_ram_loader;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;

  logic       rdy_o   [2];
  logic [7:0] addr_o  [2];
  logic       we_o    [2];
  logic       oe_o    [2];
  logic       busy_o  [2];
  logic       halt_o  [2];
  logic       done_o  [2];
  logic       error_o [2];
  logic [1:0] ec_o    [2];
  logic [7:0] bus_o   [2];

  logic       corrupt_en = 1'b0;
  int         corrupt_idx = 1;

  logic [7:0] exp_bytes [256];
  int         exp_len = 0;
  int         widx [2];
  int         ridx [2];
  logic       prev_busy [2];
  int         cyc = 0;
  int         errors = 0;
  int         checks = 0;

  always #5 clk = ~clk;

  function automatic logic [7:0] base_of(input int k);
    return (k == 0) ? 8'h10 : 8'hFE;
  endfunction

  function automatic void check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endfunction

  for (genvar gi = 0; gi < 2; gi++) begin : g_ram
    localparam logic [7:0] BASE = (gi == 0) ? 8'h10 : 8'hFE;
    wire  [7:0] ram_data;
    logic [7:0] mem [256];
    logic [7:0] rd_buf;

    // RAM model: write on we, otherwise register the read buffer; drive bus only on oe
    assign ram_data  = oe_o[gi] ? rd_buf : 8'hzz;
    assign bus_o[gi] = ram_data;

    always @(posedge clk) begin
      if (we_o[gi]) mem[addr_o[gi]] <= ram_data;
      else rd_buf <= mem[addr_o[gi]] ^
                     {7'd0, corrupt_en && (addr_o[gi] == BASE + corrupt_idx[7:0])};
    end

    ram_loader #(.BASE_ADDR(BASE)) u_dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .in_data  (in_data),
      .in_valid (in_valid),
      .in_ready (rdy_o[gi]),
      .ram_addr (addr_o[gi]),
      .ram_we   (we_o[gi]),
      .ram_oe   (oe_o[gi]),
      .ram_data (ram_data),
      .busy     (busy_o[gi]),
      .cpu_halt (halt_o[gi]),
      .done     (done_o[gi]),
      .error    (error_o[gi]),
      .err_code (ec_o[gi])
    );
  end

  function automatic logic [7:0] mem_rd(input int k, input logic [7:0] a);
    return (k == 0) ? g_ram[0].mem[a] : g_ram[1].mem[a];
  endfunction

  // Per-cycle compare: bus accesses must follow the expected image in order
  always begin
    @(posedge clk);
    #1;
    cyc++;
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        check($sformatf("dut%0d_reset_outputs", k),
              {rdy_o[k], we_o[k], oe_o[k], busy_o[k], halt_o[k], done_o[k], error_o[k],
               ec_o[k], addr_o[k]}, 0);
      end else begin
        if (!prev_busy[k] && busy_o[k]) begin
          widx[k] = 0;
          ridx[k] = 0;
        end
        check($sformatf("dut%0d_halt_eq_busy", k), halt_o[k], busy_o[k]);
        check($sformatf("dut%0d_we_oe_excl", k), we_o[k] && oe_o[k], 0);
        if (!busy_o[k])
          check($sformatf("dut%0d_idle_bus", k), {we_o[k], oe_o[k], rdy_o[k]}, 0);
        else
          check($sformatf("dut%0d_busy_status", k), {done_o[k], error_o[k], ec_o[k]}, 0);
        if (we_o[k]) begin
          check($sformatf("dut%0d_write_in_range", k), widx[k] < exp_len, 1);
          check($sformatf("dut%0d_write_addr", k), addr_o[k], 8'(base_of(k) + widx[k][7:0]));
          check($sformatf("dut%0d_write_data", k), bus_o[k], exp_bytes[widx[k][7:0]]);
          widx[k]++;
        end
        if (oe_o[k]) begin
          check($sformatf("dut%0d_read_addr", k), addr_o[k], 8'(base_of(k) + ridx[k][7:0]));
          ridx[k]++;
        end
      end
      prev_busy[k] = busy_o[k];
    end
  end

  task automatic send_byte(input logic [7:0] b, input int gap_pct);
    int guard;
    guard = 0;
    while (gap_pct > 0 && $urandom_range(99) < gap_pct && guard < 3) begin
      in_valid = 1'b0;
      @(negedge clk);
      guard++;
    end
    in_valid = 1'b1;
    in_data  = b;
    guard = 0;
    while (!rdy_o[0] && guard < 1000) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 1000) check("in_ready_timeout", 0, 1);
    @(negedge clk);
  endtask

  // Model: outcome from the byte sum and the corruption setting; latency from the frame length
  task automatic run_load(input int L, input logic [7:0] chk_b, input int gap, output int lat);
    int   sum;
    bit   s_err;
    bit   r_err;
    int   guard;
    int   entry;
    bit   idle_seen;
    sum = 0;
    idle_seen = 0;
    exp_len = L;
    for (int i = 0; i < L; i++) sum += exp_bytes[i];
    s_err = (chk_b != sum[7:0]);
    r_err = !s_err && corrupt_en && (corrupt_idx < L);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    entry = cyc;
    send_byte(L[7:0], gap);
    for (int i = 0; i < L; i++) send_byte(exp_bytes[i], gap);
    send_byte(chk_b, gap);
    in_valid = 1'b0;
    guard = 0;
    while (!(done_o[0] || error_o[0]) && guard < 3000) begin
      if (!busy_o[0]) idle_seen = 1;
      @(negedge clk);
      guard++;
    end
    if (guard >= 3000) check("done_timeout", 0, 1);
    lat = cyc - entry;
    check("busy_during_load", idle_seen, 0);
    if (gap == 0) check("latency", lat, s_err ? 2 * L + 2 : 4 * L + 3);
    for (int k = 0; k < 2; k++) begin
      check($sformatf("dut%0d_done", k), done_o[k], !(s_err || r_err));
      check($sformatf("dut%0d_error", k), error_o[k], s_err || r_err);
      check($sformatf("dut%0d_err_code", k), ec_o[k], s_err ? 1 : (r_err ? 2 : 0));
      check($sformatf("dut%0d_write_count", k), widx[k], L);
      check($sformatf("dut%0d_read_count", k), ridx[k], s_err ? 0 : L);
      for (int i = 0; i < L; i++)
        check($sformatf("dut%0d_mem_%0d", k, i), mem_rd(k, 8'(base_of(k) + i[7:0])), exp_bytes[i]);
    end
    $display("load len=%0d chk=0x%02h gap=%0d%% -> done=%0d error=%0d err_code=%0d latency=%0d",
             L, chk_b, gap, done_o[0], error_o[0], ec_o[0], lat);
  endtask

  initial begin
    int lat;
    int sum;
    logic [7:0] chk_b;
    prev_busy[0] = 1'b0;
    prev_busy[1] = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Basic three-byte load
    exp_bytes[0] = 8'h11; exp_bytes[1] = 8'h22; exp_bytes[2] = 8'h33;
    run_load(3, 8'h66, 0, lat);
    check("lit_latency_len3", lat, 15);
    check("lit_mem_10", mem_rd(0, 8'h10), 8'h11);
    check("lit_mem_12", mem_rd(0, 8'h12), 8'h33);
    check("lit_mem_wrap_00", mem_rd(1, 8'h00), 8'h33);

    // Bad stream checksum: no readback
    run_load(3, 8'h67, 0, lat);
    check("lit_latency_stream_err", lat, 8);
    check("lit_err_code_stream", ec_o[0], 1);

    // Four bytes across the 0xFF/0x00 wrap on the 0xFE instance
    exp_bytes[0] = 8'h01; exp_bytes[1] = 8'h02; exp_bytes[2] = 8'h03; exp_bytes[3] = 8'h04;
    run_load(4, 8'h0A, 0, lat);
    check("lit_mem_ff", mem_rd(1, 8'hFF), 8'h02);
    check("lit_mem_01", mem_rd(1, 8'h01), 8'h04);
    check("lit_done_len4", done_o[1], 1);

    // Full 256-byte image
    for (int i = 0; i < 256; i++) exp_bytes[i] = i[7:0];
    run_load(256, 8'h80, 0, lat);
    check("lit_latency_len256", lat, 1027);

    // Readback corruption at index 1
    exp_bytes[0] = 8'h11; exp_bytes[1] = 8'h22; exp_bytes[2] = 8'h33;
    corrupt_en = 1'b1;
    corrupt_idx = 1;
    run_load(3, 8'h66, 0, lat);
    check("lit_err_code_readback", ec_o[0], 2);
    check("lit_latency_readback", lat, 15);
    corrupt_en = 1'b0;

    // Random loads with input gaps and occasional bad checksums
    for (int r = 0; r < 6; r++) begin
      int L;
      L = $urandom_range(1, 24);
      sum = 0;
      for (int i = 0; i < L; i++) begin
        exp_bytes[i] = 8'($urandom);
        sum += exp_bytes[i];
      end
      chk_b = sum[7:0];
      if ($urandom_range(3) == 0) chk_b = chk_b ^ (8'h01 << $urandom_range(7));
      run_load(L, chk_b, 30, lat);
    end

    // Mid-load start is ignored; reset in V_READ abandons the load
    sum = 0;
    for (int i = 0; i < 5; i++) begin
      exp_bytes[i] = 8'($urandom);
      sum += exp_bytes[i];
    end
    exp_len = 5;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    send_byte(8'd5, 30);
    send_byte(exp_bytes[0], 30);
    send_byte(exp_bytes[1], 30);
    in_valid = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("busy_after_midload_start", busy_o[0], 1);
    for (int i = 2; i < 5; i++) send_byte(exp_bytes[i], 30);
    send_byte(sum[7:0], 30);
    in_valid = 1'b0;
    check("in_vread_before_rst", {busy_o[0], we_o[0], oe_o[0], rdy_o[0]}, 4'b1000);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 2; k++) begin
      check($sformatf("dut%0d_post_rst_status", k),
            {busy_o[k], done_o[k], error_o[k], ec_o[k], we_o[k]}, 0);
      check($sformatf("dut%0d_post_rst_no_readback", k), ridx[k], 0);
      check($sformatf("dut%0d_post_rst_writes", k), widx[k], 5);
      for (int i = 0; i < 5; i++)
        check($sformatf("dut%0d_post_rst_mem_%0d", k, i),
              mem_rd(k, 8'(base_of(k) + i[7:0])), exp_bytes[i]);
    end
    $display("load len=5 aborted by reset during readback");

    // Fresh load after reset
    for (int i = 0; i < 7; i++) exp_bytes[i] = 8'(8'h40 + i);
    run_load(7, 8'hD5, 0, lat);
    check("lit_done_after_rst", done_o[0], 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
